// File: rtl/count_seq_ctrl.sv
// Run sequencer for a W-bit up-counter datapath: go-rise start, clear, count to limit, done/err handshake.
// Optional completed-run statistics counter is enabled by defining COUNT_SEQ_STATS_EN.
module count_seq_ctrl #(
    parameter int W          = 7,
    parameter int WDOG_SLACK = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         go,
    input  logic         abort,
    input  logic         hold,
    input  logic [W-1:0] limit,
    input  logic [W-1:0] count,
    output logic         cnt_clr,
    output logic         cnt_inc,
    output logic         busy,
    output logic         done,
`ifdef COUNT_SEQ_STATS_EN
    output logic [7:0]   runs,
`endif
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state, w_state_next;
    logic         r_go_q;
    logic         r_go_seen_low;
    logic [W-1:0] r_lim_q, w_lim_next;
    logic [W+1:0] r_wd, w_wd_next;
    logic [W+1:0] w_wd_limit;
    logic         r_err, w_err_next;
    logic         w_rise;
    logic         w_at_limit;
    logic         w_wd_hit;
    logic         w_run_ok;

    // A level that is already high when reset releases must drop once before it can start a run.
    assign w_rise     = go & ~r_go_q & r_go_seen_low;
    assign w_at_limit = (count == r_lim_q);
    assign w_wd_limit = {2'b00, r_lim_q} + (W+2)'(WDOG_SLACK);
    assign w_wd_hit   = (r_wd == w_wd_limit);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= S_IDLE;
            r_go_q        <= 1'b0;
            r_go_seen_low <= 1'b0;
            r_lim_q       <= '0;
            r_wd          <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_go_q  <= go;
            if (!go) begin
                r_go_seen_low <= 1'b1;
            end
            r_lim_q <= w_lim_next;
            r_wd    <= w_wd_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lim_next   = r_lim_q;
        w_wd_next    = r_wd;
        w_err_next   = r_err;
        w_run_ok     = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise && !abort) begin
                    w_state_next = S_CLEAR;
                    w_lim_next   = limit;
                    w_wd_next    = '0;
                    w_err_next   = 1'b0;
                end
            end
            S_CLEAR: begin
                cnt_clr = 1'b1;
                busy    = 1'b1;
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_err_next   = 1'b0;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_err_next   = 1'b0;
                end else if (w_at_limit) begin
                    w_state_next = S_DONE;
                    w_err_next   = 1'b0;
                    w_run_ok     = 1'b1;
                end else if (w_wd_hit) begin
                    // Datapath failed to reach the limit within its increment budget.
                    w_state_next = S_DONE;
                    w_err_next   = 1'b1;
                end else if (!hold) begin
                    cnt_inc   = 1'b1;
                    w_wd_next = r_wd + 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
                err  = r_err;
                if (abort) begin
                    w_state_next = S_IDLE;
                    w_err_next   = 1'b0;
                end else if (!go) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef COUNT_SEQ_STATS_EN
    logic [7:0] r_runs;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_runs <= '0;
        end else if (w_run_ok && (r_runs != 8'hFF)) begin
            r_runs <= r_runs + 8'd1;
        end
    end

    assign runs = r_runs;
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a behavioural counter datapath (clr -> 0, inc -> +1).
// Define COUNT_SEQ_STATS_EN for both files to exercise the runs counter.
module tb_count_seq_ctrl;

    localparam int W = 7;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         go = 1'b0;
    logic         abort = 1'b0;
    logic         hold = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count;
    logic         cnt_clr, cnt_inc, busy, done, err;
`ifdef COUNT_SEQ_STATS_EN
    logic [7:0]   runs;
    int           runs_before;
`endif

    logic [W-1:0] dp_count = '0;
    logic         stuck = 1'b0;
    int           checks = 0;
    int           errors = 0;

    always #5 Clk = ~Clk;

    always_ff @(posedge Clk) begin
        if (cnt_clr) begin
            dp_count <= '0;
        end else if (cnt_inc) begin
            dp_count <= dp_count + 1'b1;
        end
    end

    assign count = stuck ? W'(3) : dp_count;

    count_seq_ctrl #(.W(W), .WDOG_SLACK(2)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .go      (go),
        .abort   (abort),
        .hold    (hold),
        .limit   (limit),
        .count   (count),
        .cnt_clr (cnt_clr),
        .cnt_inc (cnt_inc),
        .busy    (busy),
        .done    (done),
`ifdef COUNT_SEQ_STATS_EN
        .runs    (runs),
`endif
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-18s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Raises go and waits for done; n counts edges including the one that samples the rise.
    task automatic run_go(input int lim, input int hs, input int hl,
                          output int n, output int incs, output int clrs);
        limit = W'(lim);
        go    = 1'b1;
        n     = 0;
        incs  = 0;
        clrs  = 0;
        while (n < 100) begin
            @(posedge Clk);
            #1;
            n++;
            hold = (n >= hs) && (n < hs + hl);
            #1;
            incs += int'(cnt_inc);
            clrs += int'(cnt_clr);
            if (done) break;
        end
        hold = 1'b0;
    endtask

    initial begin
        int n, incs, clrs, k;

        // Reset and a go-low edge to arm rise detection
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clr", cnt_clr, 0);
        chk("rst_err", err, 0);
        Rst = 1'b0;
        step();
`ifdef COUNT_SEQ_STATS_EN
        chk("rst_runs", runs, 0);
`endif

        // Test 1: limit=5
        run_go(5, 0, 0, n, incs, clrs);
        chk("t1_edges", n, 8);
        chk("t1_incs", incs, 5);
        chk("t1_clrs", clrs, 1);
        chk("t1_err", err, 0);
        chk("t1_count", count, 5);
        repeat (3) step();
        chk("t1_done_held", done, 1);
`ifdef COUNT_SEQ_STATS_EN
        chk("t1_runs", runs, 1);
`endif
        go = 1'b0;
        step();
        chk("t1_idle_done", done, 0);
        chk("t1_idle_busy", busy, 0);

        // Test 2: limit=0
        run_go(0, 0, 0, n, incs, clrs);
        chk("t2_edges", n, 3);
        chk("t2_incs", incs, 0);
        chk("t2_err", err, 0);
        go = 1'b0;
        step();

        // Test 3: limit=10 with a 4-cycle hold mid-run
        run_go(10, 5, 4, n, incs, clrs);
        chk("t3_edges", n, 17);
        chk("t3_incs", incs, 10);
        chk("t3_err", err, 0);
        chk("t3_count", count, 10);
        go = 1'b0;
        step();

        // Test 4: limit=20, abort once count reaches 7
        limit = W'(20);
        go    = 1'b1;
        k     = 0;
        while (k < 50 && count != W'(7)) begin
            step();
            k++;
        end
        chk("t4_reach7", count, 7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_inc", cnt_inc, 0);
        go = 1'b0;
        step();
        run_go(20, 0, 0, n, incs, clrs);
        chk("t4_edges", n, 23);
        chk("t4_incs", incs, 20);
        chk("t4_count", count, 20);
        chk("t4_err", err, 0);
        go = 1'b0;
        step();

        // Test 5: go kept high after done, then reset with go high
        run_go(3, 0, 0, n, incs, clrs);
        chk("t5_edges", n, 6);
        clrs = 0;
        repeat (10) begin
            step();
            clrs += int'(cnt_clr);
        end
        chk("t5_no_rerun", clrs, 0);
        chk("t5_done_held", done, 1);
        Rst = 1'b1;
        step();
        chk("t5_rst_done", done, 0);
        Rst = 1'b0;
        clrs = 0;
        k    = 0;
        repeat (5) begin
            step();
            clrs += int'(cnt_clr);
            k    += int'(busy);
        end
        chk("t5_rst_no_clr", clrs, 0);
        chk("t5_rst_no_busy", k, 0);
        go = 1'b0;
        step();
        run_go(2, 0, 0, n, incs, clrs);
        chk("t5_rerun_edges", n, 5);
        go = 1'b0;
        step();

        // Abort coincident with a go rise in IDLE: no run
        go    = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        k = 0;
        repeat (4) begin
            step();
            k += int'(busy) + int'(cnt_clr);
        end
        chk("t7_abort_rise", k, 0);
        go = 1'b0;
        step();

        // Test 6: datapath stuck at 3, limit=6 -> watchdog
`ifdef COUNT_SEQ_STATS_EN
        runs_before = int'(runs);
`endif
        stuck = 1'b1;
        run_go(6, 0, 0, n, incs, clrs);
        chk("t6_edges", n, 11);
        chk("t6_incs", incs, 8);
        chk("t6_err", err, 1);
`ifdef COUNT_SEQ_STATS_EN
        chk("t6_runs", runs, 32'(runs_before));
`endif
        go    = 1'b0;
        stuck = 1'b0;
        step();
        chk("t6_idle_err", err, 0);
        chk("t6_idle_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
